// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI mode constants, FSM state type and shared frame width
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchroniser with a third flop for rise/fall detect
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {3{RESET_VAL}};
    else        r_sync <= {r_sync[1:0], i_async};
  end

  assign o_rise = r_sync[1] & ~r_sync[2];
  assign o_fall = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI target, one DATA_WIDTH word in and out per frame slot
module spi_slave
  import spi_pkg::*;
#(
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0,
  parameter int   DATA_WIDTH = SPI_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  nss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] data_send,
  input  logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_recv,
  output logic                  recv_completed,
  output logic                  send_completed,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_tx_hold;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_mosi_meta;
  logic                  r_mosi_sync;

  logic                  w_sck_rise, w_sck_fall, w_nss_rise, w_nss_fall;
  logic                  w_lead, w_trail, w_sample, w_shift, w_last, w_partial;
  logic [DATA_WIDTH-1:0] w_tx_next, w_load_shift, w_rx_next;
  logic [DATA_WIDTH:0]   w_rx_cat;
  logic                  w_load_miso;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_nss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(nss),
    .o_rise (w_nss_rise),
    .o_fall (w_nss_fall)
  );

  // mosi only needs two flops: its synced copy lines up with sck's edge-detect stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_lead    = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail   = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sample  = CPHA ? w_trail : w_lead;
  assign w_shift   = CPHA ? w_lead : w_trail;
  assign w_last    = w_sample && (r_bit_cnt == LAST_BIT);
  assign w_partial = w_sample ? (r_bit_cnt != LAST_BIT) : (r_bit_cnt != '0);

  // A strobe landing on a load cycle bypasses the holding register
  assign w_tx_next    = data_valid ? data_send : r_tx_hold;
  assign w_load_shift = CPHA ? w_tx_next : (w_tx_next << 1);
  assign w_load_miso  = CPHA ? miso : w_tx_next[DATA_WIDTH-1];
  assign w_rx_cat     = {r_rx_shift, r_mosi_sync};
  assign w_rx_next    = w_rx_cat[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_tx_hold      <= '0;
      r_tx_shift     <= '0;
      r_rx_shift     <= '0;
      r_bit_cnt      <= '0;
      miso           <= 1'b0;
      miso_oe        <= 1'b0;
      data_recv      <= '0;
      recv_completed <= 1'b0;
      send_completed <= 1'b0;
      frame_abort    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      recv_completed <= 1'b0;
      send_completed <= 1'b0;
      frame_abort    <= 1'b0;
      if (data_valid) r_tx_hold <= data_send;

      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          miso_oe   <= 1'b0;
          if (w_nss_fall) begin
            r_state    <= ACTIVE;
            busy       <= 1'b1;
            miso_oe    <= 1'b1;
            r_tx_shift <= w_load_shift;
            miso       <= w_load_miso;
          end
        end

        ACTIVE: begin
          if (w_sample) begin
            r_rx_shift <= w_rx_next;
            if (w_last) begin
              data_recv      <= w_rx_next;
              recv_completed <= 1'b1;
              send_completed <= 1'b1;
              r_bit_cnt      <= '0;
              r_tx_shift     <= w_load_shift;
              miso           <= w_load_miso;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end else if (w_shift && (CPHA || r_bit_cnt != '0)) begin
            // CPHA=0 skips the trailing edge after the final sample; the reload already set the MSB
            miso       <= r_tx_shift[DATA_WIDTH-1];
            r_tx_shift <= r_tx_shift << 1;
          end

          if (w_nss_rise) begin
            r_state     <= IDLE;
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
            r_bit_cnt   <= '0;
            frame_abort <= w_partial;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench: one slave per SPI mode driven by a behavioural master
module tb_spi_slave;
  import spi_pkg::*;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sck, nss, dv;
  logic [3:0] miso, miso_oe, recv_c, send_c, abort, busy;
  logic       mosi;
  logic [7:0] dsend;
  logic [7:0] drecv [4];

  int         nvec = 0;
  int         nerr = 0;
  logic [9:0] expq [$];
  logic [7:0] exp_last [4];
  int         exp_abort [4];
  int         npulse [4];
  logic       msb_seen;
  logic [7:0] r0, r1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam logic [1:0] MD = 2'(g);
    spi_slave #(.CPOL(MD[1]), .CPHA(MD[0]), .DATA_WIDTH(SPI_DATA_WIDTH)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sck           (sck[g]),
      .nss           (nss[g]),
      .mosi          (mosi),
      .miso          (miso[g]),
      .miso_oe       (miso_oe[g]),
      .data_send     (dsend),
      .data_valid    (dv[g]),
      .data_recv     (drecv[g]),
      .recv_completed(recv_c[g]),
      .send_completed(send_c[g]),
      .frame_abort   (abort[g]),
      .busy          (busy[g])
    );
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int m, input logic [7:0] v);
    dsend = v;
    dv[m] = 1'b1;
    wait_clk(1);
    dv[m] = 1'b0;
  endtask

  // Model: every completed byte must surface exactly once as a pulse with data_recv equal to the
  // byte the master sent; between pulses data_recv holds; aborts must be announced by the master.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      for (int m = 0; m < 4; m++) begin
        exp_last[m]  = 8'h00;
        exp_abort[m] = 0;
        npulse[m]    = 0;
      end
    end else begin
      for (int m = 0; m < 4; m++) begin
        chk("send_eq_recv_pulse", send_c[m], recv_c[m]);
        if (recv_c[m]) begin
          npulse[m]++;
          if (expq.size() == 0 || expq[0][9:8] != 2'(m)) begin
            chk("unexpected_recv_pulse", recv_c[m], 0);
          end else begin
            exp_last[m] = expq[0][7:0];
            void'(expq.pop_front());
          end
        end
        chk("data_recv", drecv[m], exp_last[m]);
        chk("miso_oe_vs_busy", miso_oe[m], busy[m]);
        if (abort[m]) begin
          chk("unexpected_abort", (exp_abort[m] > 0), 1);
          if (exp_abort[m] > 0) exp_abort[m]--;
        end
      end
    end
  end

  task automatic xfer(input int m, input int nb, input logic [7:0] t0, input logic [7:0] t1,
                      input int abort_at, input int rst_at,
                      output logic [7:0] o0, output logic [7:0] o1);
    logic       cpol, cpha;
    logic [7:0] tb_byte, rb;
    cpol = m[1];
    cpha = m[0];
    o0 = 8'h00;
    o1 = 8'h00;
    nss[m] = 1'b0;
    if (!cpha) mosi = t0[7];
    wait_clk(3);
    msb_seen = miso[m];
    chk("busy_in_frame", busy[m], 1);
    wait_clk(1);
    for (int b = 0; b < nb; b++) begin
      tb_byte = (b == 0) ? t0 : t1;
      rb = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i == abort_at) begin
          exp_abort[m]++;
          nss[m] = 1'b1;
          wait_clk(6);
          return;
        end
        if (b * 8 + i == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_miso", miso[m], 0);
          chk("rst_miso_oe", miso_oe[m], 0);
          chk("rst_busy", busy[m], 0);
          chk("rst_data_recv", drecv[m], 0);
          chk("rst_pulses", {recv_c[m], send_c[m], abort[m]}, 0);
          nss[m] = 1'b1;
          sck[m] = cpol;
          wait_clk(3);
          rst_n = 1'b1;
          wait_clk(2);
          return;
        end
        if (cpha) mosi = tb_byte[7-i];
        else      rb = {rb[6:0], miso[m]};
        if (!cpha && i == 7) expq.push_back({2'(m), tb_byte});
        sck[m] = ~cpol;
        wait_clk(H);
        if (cpha)          rb = {rb[6:0], miso[m]};
        else if (i < 7)    mosi = tb_byte[6-i];
        else if (b + 1 < nb) mosi = t1[7];
        if (cpha && i == 7) expq.push_back({2'(m), tb_byte});
        sck[m] = cpol;
        wait_clk(H);
      end
      if (b == 0) o0 = rb;
      else        o1 = rb;
    end
    nss[m] = 1'b1;
    wait_clk(6);
    chk("queue_drained", expq.size(), 0);
    chk("busy_idle", busy[m], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    sck   = 4'b1100;
    nss   = 4'hF;
    dv    = 4'h0;
    mosi  = 1'b0;
    dsend = 8'h00;
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      chk("reset_miso", miso[m], 0);
      chk("reset_miso_oe", miso_oe[m], 0);
      chk("reset_busy", busy[m], 0);
      chk("reset_data_recv", drecv[m], 0);
      chk("reset_pulses", {recv_c[m], send_c[m], abort[m]}, 0);
    end
    rst_n = 1'b1;
    wait_clk(3);

    load(3, 8'h3C);
    xfer(int'(MODE3), 1, 8'hD5, 8'h00, -1, -1, r0, r1);
    chk("m3_master_rx", r0, 8'h3C);
    chk("m3_data_recv", drecv[3], 8'hD5);
    chk("m3_pulse_count", npulse[3], 1);

    xfer(int'(MODE3), 1, 8'h96, 8'h00, -1, -1, r0, r1);
    chk("m3_resend_rx", r0, 8'h3C);
    chk("m3_resend_recv", drecv[3], 8'h96);

    load(0, 8'hA5);
    xfer(int'(MODE0), 1, 8'h5A, 8'h00, -1, -1, r0, r1);
    chk("m0_master_rx", r0, 8'hA5);
    chk("m0_data_recv", drecv[0], 8'h5A);
    chk("m0_msb_before_sck", msb_seen, 1);

    load(1, 8'h11);
    fork
      xfer(int'(MODE1), 2, 8'h81, 8'h42, -1, -1, r0, r1);
      begin
        wait_clk(1);
        load(1, 8'h22);
      end
    join
    chk("m1_master_rx0", r0, 8'h22);
    chk("m1_master_rx1", r1, 8'h22);
    chk("m1_data_recv", drecv[1], 8'h42);
    chk("m1_pulse_count", npulse[1], 2);

    load(2, 8'h0F);
    xfer(int'(MODE2), 1, 8'h69, 8'h00, -1, -1, r0, r1);
    chk("m2_master_rx", r0, 8'h0F);
    chk("m2_data_recv", drecv[2], 8'h69);
    xfer(int'(MODE2), 1, 8'hA3, 8'h00, 3, -1, r0, r1);
    chk("m2_abort_seen", exp_abort[2], 0);
    chk("m2_recv_kept", drecv[2], 8'h69);
    chk("m2_no_pulse_on_abort", npulse[2], 1);
    xfer(int'(MODE2), 1, 8'hF0, 8'h00, -1, -1, r0, r1);
    chk("m2_after_abort_rx", r0, 8'h0F);
    chk("m2_after_abort_recv", drecv[2], 8'hF0);

    xfer(int'(MODE3), 1, 8'hAB, 8'h00, -1, 4, r0, r1);
    for (int m = 0; m < 4; m++) chk("post_reset_recv", drecv[m], 0);
    xfer(int'(MODE3), 1, 8'h77, 8'h00, -1, -1, r0, r1);
    chk("m3_post_reset_recv", drecv[3], 8'h77);
    chk("m3_post_reset_rx", r0, 8'h00);
    chk("m3_post_reset_pulses", npulse[3], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave (target) endpoint: the far end of spi_master on the same 4-wire bus (sck, nss, mosi, miso). It runs entirely in the system clk domain and oversamples the asynchronous bus pins. It shifts one byte in from mosi and one byte out on miso per 8 sck cycles, MSB first, for all four CPOL/CPHA modes. Parallel side presents the same data_send / data_valid / data_recv / completed-pulse style as spi_master, so the two can be looped back on an FPGA.

Parameters:
CPOL, 1'b0, sck idle level; must match master.
CPHA, 1'b0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading, sample on trailing.
DATA_WIDTH, 8, bits per frame.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
sck  input  1  SPI clock from master, asynchronous to clk.
nss  input  1  slave select, active low, asynchronous.
mosi  input  1  master-out data.
miso  output  1  slave-out data.
miso_oe  output  1  miso drive enable; high only while nss (synchronised) is low.
data_send  input  DATA_WIDTH  byte to transmit.
data_valid  input  1  1-cycle strobe; writes data_send into the TX holding register.
data_recv  output  DATA_WIDTH  last complete received byte.
recv_completed  output  1  1-cycle pulse when data_recv updates.
send_completed  output  1  1-cycle pulse when a TX byte has been fully shifted out (same cycle as recv_completed).
frame_abort  output  1  1-cycle pulse when nss deasserts with a partial byte in flight.
busy  output  1  high while in ACTIVE state.

Behaviour:
- Reset (async, rst_n low): miso=0, miso_oe=0, data_recv=0, all pulses 0, busy=0, TX holding=0, shift regs=0, bit counter=0, FSM=IDLE. Synchroniser flops reset to sck=CPOL, nss=1, mosi=0.
- Input conditioning: sck, nss, mosi each pass through 2 FF; a third FF on sck and nss gives edge detect. Leading edge = transition away from CPOL; trailing = back to CPOL. Pin-to-internal-event latency: 3 clk.
- Timing requirement: sck half-period >= 4 clk; nss-low to first sck edge >= 4 clk. This matches spi_master with CLK_DIV >= 4. Faster sck is unsupported.
- TX holding register: written on any cycle data_valid=1, including mid-frame. It is copied into the TX shift register at frame start and at every byte boundary while nss stays low. It is never cleared, so an unrefreshed slave resends its last byte.
- FSM IDLE: miso_oe=0, bit counter held 0. On synced nss falling edge: load TX shift register, busy=1, go ACTIVE. With CPHA=0, miso = TX MSB from this cycle.
- FSM ACTIVE, sample edge (leading if CPHA=0, trailing if CPHA=1): shift synced mosi into RX LSB; increment bit counter.
- On the DATA_WIDTH-th sample: data_recv <= full RX word; pulse recv_completed and send_completed; counter wraps to 0; reload TX shift register from holding.
- FSM ACTIVE, shift edge (trailing if CPHA=0, leading if CPHA=1): present next TX bit on miso.
  - CPHA=0: no shift on the trailing edge that follows the final sample; the reload supplies the next MSB.
  - CPHA=1: the first leading edge of each byte presents the MSB.
- Back-to-back bytes: nss held low, next byte continues with no gap or extra state.
- nss rising (synced) in ACTIVE: go IDLE, busy=0, miso_oe=0.
  - If bit counter != 0: pulse frame_abort, discard partial RX, leave data_recv unchanged, no completed pulse.
  - If a final sample and nss rising coincide in the same clk: the byte completes (pulses fire) and no frame_abort.
- data_valid and reload in the same cycle: the new data_send goes directly to the shift register and to holding.
- sck edges while nss high are ignored.

Decomposition:
- Shared package spi_pkg: SPI mode constants (MODE0..MODE3 as {CPOL,CPHA}), the FSM state enum (IDLE, ACTIVE), and the DATA_WIDTH default shared with spi_master.
- One sub-module, spi_sync_edge: 2-FF synchroniser plus rise/fall detect with a reset-value parameter. It is instantiated for sck and nss; mosi uses a plain 2-FF path.

Test Plan:
- Mode 3, CLK_DIV=4 master: load slave 0x3C, master sends 0xD5 -> slave data_recv=0xD5 with one recv_completed pulse; master receives 0x3C; busy low after nss rise.
- Mode 0: slave 0xA5, master 0x5A -> data_recv=0x5A, master gets 0xA5; miso=1 (bit7 of 0xA5) within 3 clk of nss fall, before the first sck edge.
- Back-to-back, mode 1, nss held low: slave loads 0x11, then strobes 0x22 mid-byte; master sends 0x81, 0x42 -> two recv_completed pulses, data_recv 0x81 then 0x42; master gets 0x22, 0x22 (the mid-byte strobe overwrites holding before the first load boundary).
- Abort: nss raised after 3 sck cycles in mode 2 -> frame_abort pulse; data_recv keeps its previous value; next full frame 0xF0 -> data_recv=0xF0.
- No refresh: second frame with no data_valid -> slave resends the previous byte (0x3C).
- Reset mid-frame: rst_n low during bit 4 -> all outputs at reset values immediately; after release and a new frame 0x77 -> data_recv=0x77.
